// File: rtl/carrier_syn_pkg.sv
// Shared defaults and types for the multi-channel carrier sync generator.
`timescale 1ns/1ps
package carrier_syn_pkg;

    localparam int CNT_W_DEF = 16;
    localparam int N_CH_DEF  = 4;

    typedef logic [CNT_W_DEF-1:0] cnt_t;

    localparam logic SYN_RST_LEVEL = 1'b1;

endpackage

// File: rtl/carrier_syn_gen_mc_ch.sv
// One sync channel: clamps its phase to the active period and toggles its
// square wave when the shared master counter reaches that point.
`timescale 1ns/1ps
module carrier_syn_ch
    import carrier_syn_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             i_clk_20M,
    input  logic             i_reset,
    input  logic             i_enable,
    input  logic [CNT_W-1:0] i_cnt,
    input  logic [CNT_W-1:0] i_period,
    input  logic [CNT_W-1:0] i_phase,
    output logic             o_syn
);

    logic [CNT_W-1:0] ph_eff;
    logic             syn_q;
    logic             syn_d;

    always_comb begin
        // NOTE: defaults come first so every path assigns every output (no latch).
        ph_eff = (i_phase > i_period) ? i_period : i_phase;
        syn_d  = syn_q;
        if (i_enable && (i_cnt == ph_eff)) begin
            syn_d = ~syn_q;
        end
    end

    // NOTE: sequential state uses <= so all flops update from pre-edge values.
    always_ff @(posedge i_clk_20M) begin
        if (i_reset) begin
            syn_q <= SYN_RST_LEVEL;
        end else begin
            syn_q <= syn_d;
        end
    end

    assign o_syn = syn_q;

endmodule

// File: rtl/carrier_syn_gen_mc.sv
// Shared master counter with N_CH phase-shifted sync outputs and a
// double-buffered period/phase update applied at the master wrap.
// Optional triangle counter output when CARRIER_SYN_TRI_EN is defined.
`timescale 1ns/1ps
module carrier_syn_gen_mc
    import carrier_syn_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int N_CH  = N_CH_DEF
) (
    input  logic                  i_clk_20M,
    input  logic                  i_reset,
    input  logic                  i_enable,
    input  logic [CNT_W-1:0]      i_period_cnt,
    input  logic [N_CH*CNT_W-1:0] i_phase_cnt,
    input  logic                  i_load,
`ifdef CARRIER_SYN_TRI_EN
    output logic [CNT_W-1:0]      o_tri_cnt,
`endif
    output logic [N_CH-1:0]       o_syn_out,
    output logic                  o_sync_pulse,
    output logic                  o_load_ack
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [CNT_W-1:0]      per_act_q, per_act_d;
    logic [CNT_W-1:0]      per_pend_q, per_pend_d;
    logic [N_CH*CNT_W-1:0] ph_act_q, ph_act_d;
    logic [N_CH*CNT_W-1:0] ph_pend_q, ph_pend_d;
    logic                  pend_q, pend_d;
    logic                  pulse_q;
    logic                  ack_q;
    logic                  wrap;
    logic                  apply;

    always_comb begin
        wrap       = i_enable && (cnt_q == per_act_q);
        apply      = wrap && pend_q && !i_load;
        cnt_d      = cnt_q;
        per_act_d  = per_act_q;
        ph_act_d   = ph_act_q;
        per_pend_d = per_pend_q;
        ph_pend_d  = ph_pend_q;
        pend_d     = pend_q;
        if (i_enable) begin
            cnt_d = wrap ? '0 : cnt_q + CNT_ONE;
        end
        if (apply) begin
            per_act_d = per_pend_q;
            ph_act_d  = ph_pend_q;
            pend_d    = 1'b0;
        end
        // A load on the wrap cycle blocks apply above, so it only refreshes pending.
        if (i_load) begin
            per_pend_d = i_period_cnt;
            ph_pend_d  = i_phase_cnt;
            pend_d     = 1'b1;
        end
    end

    always_ff @(posedge i_clk_20M) begin
        if (i_reset) begin
            cnt_q     <= '0;
            per_act_q <= i_period_cnt;
            ph_act_q  <= i_phase_cnt;
            pend_q    <= 1'b0;
            pulse_q   <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            per_act_q <= per_act_d;
            ph_act_q  <= ph_act_d;
            pend_q    <= pend_d;
            pulse_q   <= wrap;
            ack_q     <= apply;
        end
    end

    // NOTE: pending values have no reset; pend_q alone decides whether they are used.
    always_ff @(posedge i_clk_20M) begin
        per_pend_q <= per_pend_d;
        ph_pend_q  <= ph_pend_d;
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        carrier_syn_ch #(.CNT_W(CNT_W)) u_ch (
            .i_clk_20M (i_clk_20M),
            .i_reset   (i_reset),
            .i_enable  (i_enable),
            .i_cnt     (cnt_q),
            .i_period  (per_act_q),
            .i_phase   (ph_act_q[k*CNT_W +: CNT_W]),
            .o_syn     (o_syn_out[k])
        );
    end

`ifdef CARRIER_SYN_TRI_EN
    logic             dir_q;
    logic [CNT_W-1:0] tri_q;

    always_ff @(posedge i_clk_20M) begin
        if (i_reset) begin
            dir_q <= 1'b1;
            tri_q <= '0;
        end else if (i_enable) begin
            tri_q <= dir_q ? cnt_q : per_act_q - cnt_q;
            if (wrap) begin
                dir_q <= ~dir_q;
            end
        end
    end

    assign o_tri_cnt = tri_q;
`endif

    assign o_sync_pulse = pulse_q;
    assign o_load_ack   = ack_q;

endmodule
